// File: rtl/lcd_fb_arbiter.sv
// Single-port frame-buffer arbiter: display scan reads always win the RAM slot,
// writer pixels are buffered in a small FIFO and drained into free slots.
module lcd_fb_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 16,
    parameter int FB_WORDS   = 384000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              lcd_clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              fifo_empty,
    output logic              wr_err
);
    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W:0] FB_LIM  = (ADDR_W+1)'(FB_WORDS);
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count, count_next;
    logic              push, pop, rd_slot, disp_in_range, head_in_range;
    logic              req_p1, req_p2, rd_p1, rd_p2;

    assign disp_in_range = {1'b0, disp_addr} < FB_LIM;
    assign head_in_range = {1'b0, fifo_addr[rd_ptr]} < FB_LIM;
    // An out-of-range display request needs no RAM read, so it leaves the slot free.
    assign rd_slot    = disp_req & disp_in_range;
    assign pop        = !rd_slot && (count != '0);
    assign push       = wr_valid & wr_ready;
    assign fifo_empty = (count == '0);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge lcd_clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge lcd_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            wr_ready   <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            wr_err     <= 1'b0;
            req_p1     <= 1'b0;
            req_p2     <= 1'b0;
            rd_p1      <= 1'b0;
            rd_p2      <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else begin
            count    <= count_next;
            wr_ready <= count_next < DEPTH_C;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            ram_en <= rd_slot | (pop & head_in_range);
            ram_we <= pop & head_in_range;
            if (rd_slot) begin
                ram_addr <= disp_addr;
            end else if (pop && head_in_range) begin
                ram_addr  <= fifo_addr[rd_ptr];
                ram_wdata <= fifo_data[rd_ptr];
            end
            if (pop && !head_in_range) wr_err <= 1'b1;

            // Read return pipeline: command stage, RAM data stage, output register.
            req_p1     <= disp_req;
            rd_p1      <= rd_slot;
            req_p2     <= req_p1;
            rd_p2      <= rd_p1;
            disp_valid <= req_p2;
            if (req_p2) disp_data <= rd_p2 ? ram_rdata : '0;
        end
    end
endmodule
